// File: rtl/neural_pkt_pkg.sv
// Shared types and helpers for the neural packet serializer slice.
package neural_pkt_pkg;

  localparam int WORDS_PER_PKT = 4;

  typedef struct packed {
    logic [31:0] ts;
    logic [3:0]  ch;
    logic [15:0] data;
    logic [11:0] rsvd;
  } neural_pkt_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

  // Folds the upper 52 bits into 12 so it can occupy the reserved field.
  function automatic logic [11:0] pkt_checksum(input logic [63:0] p);
    return p[63:52] ^ p[51:40] ^ p[39:28] ^ p[27:16] ^ {p[15:12], 8'h00};
  endfunction

endpackage

// File: rtl/neural_pkt_fifo.sv
// Synchronous packet FIFO; pushes while full and pops while empty are ignored.
module neural_pkt_fifo
  import neural_pkt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             sensor_clk,
  input  logic             sensor_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];
  assign level    = level_reg;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge sensor_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/neural_packet_serializer.sv
// Buffers 64-bit framed packets and emits them as four 16-bit words, MSB first.
// Optional build macro NPS_CHECKSUM_EN replaces bits [11:0] with a checksum on push.
module neural_packet_serializer
  import neural_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int PACKET_WIDTH = 64,
  parameter int WORD_WIDTH   = 16
) (
  input  logic                            sensor_clk,
  input  logic                            sensor_rst_n,
  input  logic [PACKET_WIDTH-1:0]         pkt_in,
  input  logic                            pkt_in_valid,
  output logic [WORD_WIDTH-1:0]           out_word,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [15:0]                     drop_cnt
);

  localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_PKT - 1);

  ser_state_t              state_reg;
  logic [PACKET_WIDTH-1:0] shift_reg;
  logic [1:0]              idx_reg;
  logic [15:0]             drop_cnt_reg;
  neural_pkt_t             wr_pkt;
  logic [PACKET_WIDTH-1:0] head_pkt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    handshake;
  logic                    pop;

  always_comb begin
    wr_pkt = neural_pkt_t'(pkt_in);
`ifdef NPS_CHECKSUM_EN
    wr_pkt.rsvd = pkt_checksum(pkt_in);
`endif
  end

  neural_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_fifo (
    .sensor_clk   (sensor_clk),
    .sensor_rst_n (sensor_rst_n),
    .push         (pkt_in_valid),
    .push_data    (PACKET_WIDTH'(wr_pkt)),
    .pop          (pop),
    .pop_data     (head_pkt),
    .level        (fifo_level),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign handshake = (state_reg == ST_SEND) && out_ready;
  // Reloading on the last handshake keeps back-to-back packets gapless.
  assign pop = !fifo_empty &&
               ((state_reg == ST_IDLE) || (handshake && idx_reg == LAST_IDX));

  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
    end else if (pop) begin
      state_reg <= ST_SEND;
      shift_reg <= head_pkt;
      idx_reg   <= '0;
    end else if (handshake) begin
      shift_reg <= shift_reg << WORD_WIDTH;
      idx_reg   <= idx_reg + 1'b1;
      if (idx_reg == LAST_IDX) state_reg <= ST_IDLE;
    end
  end

  // Fullness is the pre-pop level, so a push colliding with a pop from full is lost.
  always_ff @(posedge sensor_clk or negedge sensor_rst_n) begin
    if (!sensor_rst_n) begin
      drop_cnt_reg <= '0;
    end else if (pkt_in_valid && fifo_full && drop_cnt_reg != 16'hFFFF) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign out_word  = shift_reg[PACKET_WIDTH-1 -: WORD_WIDTH];
  assign out_valid = (state_reg == ST_SEND);
  assign out_sop   = out_valid && (idx_reg == 2'd0);
  assign out_eop   = out_valid && (idx_reg == LAST_IDX);
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_neural_packet_serializer.sv
// Directed bench for neural_packet_serializer; honours NPS_CHECKSUM_EN when defined.
module tb_neural_packet_serializer;

  localparam logic [63:0] SPEC_PKT = 64'h0000_0010_3ABC_D000;
`ifdef NPS_CHECKSUM_EN
  localparam logic [15:0] SPEC_LAST = 16'hD6BF;
`else
  localparam logic [15:0] SPEC_LAST = 16'hD000;
`endif

  logic        sensor_clk = 1'b0;
  logic        sensor_rst_n;
  logic [63:0] pkt_in;
  logic        pkt_in_valid;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [3:0]  fifo_level;
  logic [15:0] drop_cnt;

  int check_cnt = 0;
  int err_cnt   = 0;

  logic [63:0] ovf_pkts [12];

  always #5 sensor_clk = ~sensor_clk;

  neural_packet_serializer #(
    .FIFO_DEPTH   (8),
    .PACKET_WIDTH (64),
    .WORD_WIDTH   (16)
  ) dut (
    .sensor_clk   (sensor_clk),
    .sensor_rst_n (sensor_rst_n),
    .pkt_in       (pkt_in),
    .pkt_in_valid (pkt_in_valid),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .fifo_level   (fifo_level),
    .drop_cnt     (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Independent reference for the last word of a stored packet.
  function automatic logic [15:0] exp_last(input logic [63:0] p);
`ifdef NPS_CHECKSUM_EN
    logic [11:0] a, b, c, d, e;
    a = p[63:52];
    b = p[51:40];
    c = p[39:28];
    d = p[27:16];
    e = {p[15:12], 8'h00};
    return {p[15:12], a ^ b ^ c ^ d ^ e};
`else
    return p[15:0];
`endif
  endfunction

  task automatic check_word(input string tag, input logic [15:0] w, input bit sop, input bit eop);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check_eq({tag, "_word"},  64'(out_word),  64'(w));
    check_eq({tag, "_sop"},   64'(out_sop),   64'(sop));
    check_eq({tag, "_eop"},   64'(out_eop),   64'(eop));
  endtask

  // Called at a negedge with the serializer idle and empty.
  task automatic send_spec_pkt(input string tag);
    logic [15:0] words [4];
    words[0] = 16'h0000;
    words[1] = 16'h0010;
    words[2] = 16'h3ABC;
    words[3] = SPEC_LAST;
    pkt_in = SPEC_PKT;
    pkt_in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge sensor_clk);
    pkt_in_valid = 1'b0;
    check_eq($sformatf("%s_lat_valid", tag), 64'(out_valid), 64'(1'b0));
    check_eq($sformatf("%s_lat_level", tag), 64'(fifo_level), 64'd1);
    @(negedge sensor_clk);
    for (int w = 0; w < 4; w++) begin
      check_word($sformatf("%s_w%0d", tag, w), words[w], w == 0, w == 3);
      @(negedge sensor_clk);
    end
    check_eq($sformatf("%s_done_valid", tag), 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sensor_rst_n = 1'b0;
    pkt_in = '0;
    pkt_in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ovf_pkts[k] = {16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k), 16'h4000};
    end

    repeat (2) @(negedge sensor_clk);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_word",  64'(out_word),  64'd0);
    check_eq("rst_sop",   64'(out_sop),   64'd0);
    check_eq("rst_eop",   64'(out_eop),   64'd0);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    check_eq("rst_drop",  64'(drop_cnt),  64'd0);
    sensor_rst_n = 1'b1;
    @(negedge sensor_clk);

    send_spec_pkt("single");

    // Backpressure while word 1 is presented.
    pkt_in = SPEC_PKT;
    pkt_in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge sensor_clk);
    pkt_in_valid = 1'b0;
    @(negedge sensor_clk);
    check_word("bp_w0", 16'h0000, 1'b1, 1'b0);
    @(negedge sensor_clk);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_word($sformatf("bp_hold%0d", i), 16'h0010, 1'b0, 1'b0);
      @(negedge sensor_clk);
    end
    out_ready = 1'b1;
    check_word("bp_w1", 16'h0010, 1'b0, 1'b0);
    @(negedge sensor_clk);
    check_word("bp_w2", 16'h3ABC, 1'b0, 1'b0);
    @(negedge sensor_clk);
    check_word("bp_w3", SPEC_LAST, 1'b0, 1'b1);
    @(negedge sensor_clk);
    check_eq("bp_done_valid", 64'(out_valid), 64'd0);

    // Overflow: 12 pushes with the output stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      pkt_in = ovf_pkts[k];
      pkt_in_valid = 1'b1;
      @(negedge sensor_clk);
    end
    pkt_in_valid = 1'b0;
    check_eq("ovf_level", 64'(fifo_level), 64'd8);
    check_eq("ovf_drop",  64'(drop_cnt),  64'd3);
    out_ready = 1'b1;
    for (int p = 0; p < 9; p++) begin
      check_word($sformatf("ovf_p%0d_w0", p), ovf_pkts[p][63:48], 1'b1, 1'b0);
      @(negedge sensor_clk);
      check_word($sformatf("ovf_p%0d_w1", p), ovf_pkts[p][47:32], 1'b0, 1'b0);
      @(negedge sensor_clk);
      check_word($sformatf("ovf_p%0d_w2", p), ovf_pkts[p][31:16], 1'b0, 1'b0);
      @(negedge sensor_clk);
      check_word($sformatf("ovf_p%0d_w3", p), exp_last(ovf_pkts[p]), 1'b0, 1'b1);
      @(negedge sensor_clk);
    end
    check_eq("ovf_drain_valid", 64'(out_valid), 64'd0);
    check_eq("ovf_drain_level", 64'(fifo_level), 64'd0);

    // Full plus pop: push lands on the cycle the FSM pops from a full FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pkt_in = ovf_pkts[k];
      pkt_in_valid = 1'b1;
      @(negedge sensor_clk);
    end
    pkt_in_valid = 1'b0;
    check_eq("fp_level_full", 64'(fifo_level), 64'd8);
    check_eq("fp_drop_before", 64'(drop_cnt), 64'd3);
    out_ready = 1'b1;
    @(negedge sensor_clk);
    @(negedge sensor_clk);
    @(negedge sensor_clk);
    check_word("fp_w3", exp_last(ovf_pkts[0]), 1'b0, 1'b1);
    pkt_in = 64'hDEAD_BEEF_0000_0000;
    pkt_in_valid = 1'b1;
    @(negedge sensor_clk);
    pkt_in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("fp_level", 64'(fifo_level), 64'd7);
    check_eq("fp_drop",  64'(drop_cnt),  64'd4);
    check_word("fp_next_w0", ovf_pkts[1][63:48], 1'b1, 1'b0);

    // Reset asserted while word 2 is presented.
    out_ready = 1'b1;
    @(negedge sensor_clk);
    @(negedge sensor_clk);
    check_word("mr_w2", ovf_pkts[1][31:16], 1'b0, 1'b0);
    out_ready = 1'b0;
    sensor_rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 64'(out_valid), 64'd0);
    check_eq("mr_word",  64'(out_word),  64'd0);
    check_eq("mr_sop",   64'(out_sop),   64'd0);
    check_eq("mr_eop",   64'(out_eop),   64'd0);
    check_eq("mr_level", 64'(fifo_level), 64'd0);
    check_eq("mr_drop",  64'(drop_cnt),  64'd0);
    @(negedge sensor_clk);
    sensor_rst_n = 1'b1;
    @(negedge sensor_clk);
    check_eq("mr_post_valid", 64'(out_valid), 64'd0);
    send_spec_pkt("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/neural_packet_serializer.md
# neural_packet_serializer

Downstream stage of the neural packet framer on `sensor_clk`. It buffers 64-bit framed packets in a small FIFO and serializes each one into four 16-bit words over a valid/ready link toward the transport/aggregation stage. Packets that arrive while the FIFO is full are dropped and counted. The framer can issue one packet per cycle; the serializer drains one packet per four accepted words.

## Interface
- `FIFO_DEPTH`, 8 — packet entries; power of two, ≥ 2
- `PACKET_WIDTH`, 64 — fixed at 64; framed packet width
- `WORD_WIDTH`, 16 — fixed at 16; output word width
- `sensor_clk` in 1 — block clock
- `sensor_rst_n` in 1 — reset; asynchronous, active-low
- `pkt_in` in 64 — framed packet: [63:32] timestamp, [31:28] channel, [27:12] data, [11:0] zero
- `pkt_in_valid` in 1 — single-cycle packet strobe; no backpressure toward the framer
- `out_word` out 16 — serialized word
- `out_valid` out 1 — `out_word` is valid
- `out_ready` in 1 — consumer accepts the word when `out_valid && out_ready`
- `out_sop` out 1 — high on word 0 of a packet
- `out_eop` out 1 — high on word 3 of a packet
- `fifo_level` out $clog2(FIFO_DEPTH+1) — number of occupied entries
- `drop_cnt` out 16 — dropped-packet count; saturates at 0xFFFF

## Operation
- **Push:** on `pkt_in_valid`, the packet is written if the registered `fifo_level` < `FIFO_DEPTH`. Otherwise the packet is dropped and `drop_cnt` increments, saturating at 0xFFFF.
- **Full plus pop:** a push arriving while full is dropped even if a pop happens in the same cycle. Fullness is judged on the pre-pop level.
- **FSM states:** IDLE, SEND.
  - The FSM holds a 64-bit shift register and a 2-bit word index.
  - IDLE with FIFO non-empty: pop the head, load the shift register, set index to 0, go to SEND.
  - SEND: `out_word` = shift register [63:48]. On handshake, shift left 16 bits and increment the index.
  - Handshake on index 3: if the FIFO is non-empty, pop and reload in the same cycle (stay in SEND, index 0). Otherwise go to IDLE.
- **Word order:** MSB first, i.e. [63:48], [47:32], [31:16], [15:0].
- `out_sop` = SEND && index==0. `out_eop` = SEND && index==3.
- **Holding:** while `out_valid && !out_ready`, `out_word`, `out_sop` and `out_eop` hold stable.
- `fifo_level` reflects push and pop in the same cycle, giving a net change of 0.

## Timing
- **Reset values:** all outputs 0. FIFO empty, FSM in IDLE, `drop_cnt` = 0.
- Reset asserted mid-packet discards the packet in flight and all FIFO contents immediately.
- **Latency:** `pkt_in_valid` sampled at edge N with the FIFO empty and the FSM in IDLE. The pop/load occurs at edge N+1, and `out_valid` with word 0 is visible after edge N+1.
- Back-to-back packets produce no idle cycle between word 3 of one packet and word 0 of the next.
- **Throughput:** with `out_ready` held high, one word per cycle, i.e. four cycles per packet.
- **Pointers:** $clog2(FIFO_DEPTH) bits wide, wrap naturally.
- **Level arithmetic:** `fifo_level` is one bit wider than the pointers so that level == `FIFO_DEPTH` is representable.

## Configuration
- **`NPS_CHECKSUM_EN` defined:** on push, [11:0] of the stored packet is replaced by the XOR of five fields: [63:52], [51:40], [39:28], [27:16] and {[15:12], 8'h00}. The input [11:0] is ignored.
- **`NPS_CHECKSUM_EN` undefined:** the packet is stored unmodified.

## Structure
- **Package `neural_pkt_pkg`:**
  - `WORDS_PER_PKT` = 4
  - Packet struct typedef (ts, ch, data, rsvd)
  - FSM state enum
  - `pkt_checksum` function
- **Sub-module `neural_pkt_fifo`:** synchronous FIFO with push, pop, level, full and empty; registered storage.
- The top level holds the FSM, the shift register and the drop counter.

## Test plan
- **Single packet:** push 0x0000_0010_3ABC_D000 with `out_ready`=1 -> words 0x0000, 0x0010, 0x3ABC, 0xD000 on four consecutive cycles. `out_sop` on the first word, `out_eop` on the last. The first word appears two edges after the push.
- **Checksum:** same packet with `NPS_CHECKSUM_EN` -> last word 0xD6BF.
- **Backpressure:** `out_ready` low for 5 cycles during word 1 -> `out_word` stays 0x0010 with `out_valid` high. Resume -> remaining words are correct and none are duplicated.
- **Overflow:** `out_ready`=0 and 12 consecutive pushes (DEPTH 8) -> `fifo_level` = 8 (plus one packet in the shift register), `drop_cnt` = 3. Drain -> 9 packets are delivered in order.
- **Full plus pop:** push on the exact cycle the FSM pops from a full FIFO -> the push is dropped, `drop_cnt` +1, level 7.
- **Reset mid-packet:** assert `sensor_rst_n` during word 2 -> all outputs 0 at once. After release, a new push serializes normally from word 0.
